// File: rtl/cpu6502_pkg.sv
// Shared 6502 definitions: branch sequencer states, branch opcodes,
// status-register bit positions and branch decode helpers.
package cpu6502_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EVAL  = 3'd2,
        ST_TAKEN = 3'd3,
        ST_FIXUP = 3'd4,
        ST_DONE  = 3'd5
    } branch_seq_state_t;

    localparam logic [7:0] OP_BPL = 8'h10;
    localparam logic [7:0] OP_BMI = 8'h30;
    localparam logic [7:0] OP_BVC = 8'h50;
    localparam logic [7:0] OP_BVS = 8'h70;
    localparam logic [7:0] OP_BCC = 8'h90;
    localparam logic [7:0] OP_BCS = 8'hB0;
    localparam logic [7:0] OP_BNE = 8'hD0;
    localparam logic [7:0] OP_BEQ = 8'hF0;

    localparam int P_N = 7;
    localparam int P_V = 6;
    localparam int P_Z = 1;
    localparam int P_C = 0;

    // Relative branches are exactly the opcodes with low nibble 0 and bit 4 set.
    function automatic logic is_branch(input logic [7:0] op);
        return (op[4:0] == 5'b10000);
    endfunction

    // Condition of a branch opcode against the full P register.
    function automatic logic branch_taken(input logic [7:0] op, input logic [7:0] p);
        logic result;
        result = 1'b0;
        case (op)
            OP_BPL:  result = ~p[P_N];
            OP_BMI:  result =  p[P_N];
            OP_BVC:  result = ~p[P_V];
            OP_BVS:  result =  p[P_V];
            OP_BCC:  result = ~p[P_C];
            OP_BCS:  result =  p[P_C];
            OP_BNE:  result = ~p[P_Z];
            OP_BEQ:  result =  p[P_Z];
            default: result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/branch_offset_adder.sv
// Branch-target adder: next_pc plus sign-extended offset, with page-cross flag.
module branch_offset_adder (
    input  logic [15:0] next_pc_i,
    input  logic [7:0]  offset_i,
    output logic [15:0] target_o,
    output logic        page_cross_o
);

    // Target wraps modulo 2^16; a page cross is any change of the high byte.
    always_comb begin
        target_o     = next_pc_i + {{8{offset_i[7]}}, offset_i};
        page_cross_o = (next_pc_i[15:8] != target_o[15:8]);
    end

endmodule

// File: rtl/branch_sequencer.sv
// Multi-cycle 6502 relative-branch controller: fetches the offset byte,
// evaluates the condition and charges the taken / page-cross penalty cycles.
// Memory port: mem_req is a level held for the whole FETCH residency with
// mem_addr stable; a read completes on the first cycle mem_req && mem_ready,
// and mem_rdata is only looked at on that cycle.
module branch_sequencer
    import cpu6502_pkg::*;
#(
    parameter int unsigned TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  opcode,
    input  logic [15:0] pc,
    input  logic [7:0]  status_reg,
    output logic        busy,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ready,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] pc_out,
    output logic        pc_valid,
    output logic        taken,
    output logic        page_crossed,
    output logic [2:0]  cycle_count,
    output logic        illegal,
    output logic        timeout
);

    // Last wait-count value before the fetch is abandoned.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    branch_seq_state_t state_q, state_d;

    logic [7:0]  op_q, op_d;
    logic [7:0]  status_q, status_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  offset_q, offset_d;
    logic [7:0]  wait_q, wait_d;

    logic [15:0] pc_out_q, pc_out_d;
    logic        taken_q, taken_d;
    logic        cross_q, cross_d;
    logic [2:0]  cc_q, cc_d;
    logic        illegal_q, illegal_d;
    logic        timeout_q, timeout_d;

    logic [15:0] next_pc;
    logic [15:0] target;
    logic        page_cross;
    logic        cond;

    assign next_pc = pc_q + 16'd2;
    assign cond    = branch_taken(op_q, status_q);

    branch_offset_adder u_adder (
        .next_pc_i    (next_pc),
        .offset_i     (offset_q),
        .target_o     (target),
        .page_cross_o (page_cross)
    );

    // Next-state and next-result logic; every register holds by default.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        status_d  = status_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        offset_d  = offset_q;
        wait_d    = wait_q;
        pc_out_d  = pc_out_q;
        taken_d   = taken_q;
        cross_d   = cross_q;
        cc_d      = cc_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;

        case (state_q)
            ST_IDLE: begin
                wait_d = 8'd0;
                if (start) begin
                    if (is_branch(opcode)) begin
                        op_d     = opcode;
                        status_d = status_reg;
                        pc_d     = pc;
                        addr_d   = pc + 16'd1;
                        state_d  = ST_FETCH;
                    end else begin
                        // Not ours: report straight away without touching memory.
                        pc_out_d  = pc;
                        taken_d   = 1'b0;
                        cross_d   = 1'b0;
                        cc_d      = 3'd0;
                        illegal_d = 1'b1;
                        timeout_d = 1'b0;
                        state_d   = ST_DONE;
                    end
                end
            end
            ST_FETCH: begin
                if (mem_ready) begin
                    offset_d = mem_rdata;
                    state_d  = ST_EVAL;
                end else if (wait_q == WAIT_LAST) begin
                    // Give up on the offset and fall through to the next instruction.
                    pc_out_d  = next_pc;
                    taken_d   = 1'b0;
                    cross_d   = 1'b0;
                    cc_d      = 3'd0;
                    illegal_d = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_EVAL: begin
                taken_d   = cond;
                cross_d   = cond & page_cross;
                illegal_d = 1'b0;
                timeout_d = 1'b0;
                if (cond) begin
                    state_d = ST_TAKEN;
                end else begin
                    pc_out_d = next_pc;
                    cc_d     = 3'd2;
                    state_d  = ST_DONE;
                end
            end
            ST_TAKEN: begin
                pc_out_d = target;
                if (page_cross) begin
                    state_d = ST_FIXUP;
                end else begin
                    cc_d    = 3'd3;
                    state_d = ST_DONE;
                end
            end
            ST_FIXUP: begin
                cc_d    = 3'd4;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, latched request and result registers; reset drops any pending fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= 8'h00;
            status_q  <= 8'h00;
            pc_q      <= 16'h0000;
            addr_q    <= 16'h0000;
            offset_q  <= 8'h00;
            wait_q    <= 8'd0;
            pc_out_q  <= 16'h0000;
            taken_q   <= 1'b0;
            cross_q   <= 1'b0;
            cc_q      <= 3'd0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            status_q  <= status_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            offset_q  <= offset_d;
            wait_q    <= wait_d;
            pc_out_q  <= pc_out_d;
            taken_q   <= taken_d;
            cross_q   <= cross_d;
            cc_q      <= cc_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign mem_req      = (state_q == ST_FETCH);
    assign pc_valid     = (state_q == ST_DONE);
    assign mem_addr     = addr_q;
    assign pc_out       = pc_out_q;
    assign taken        = taken_q;
    assign page_crossed = cross_q;
    assign cycle_count  = cc_q;
    assign illegal      = illegal_q;
    assign timeout      = timeout_q;

endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Multi-cycle controller that executes 6502 relative-branch instructions around the core's branch-target datapath. On a start pulse it latches the opcode, PC and status flags, fetches the signed offset byte from PC+1 over a ready-handshake memory port, evaluates the condition, and inserts the 6502 taken and page-cross penalty cycles. It ends by presenting the new PC with a one-cycle valid pulse. It sits between the CPU's main decode FSM and the memory arbiter, and owns the PC update for opcodes x10 with x odd, i.e. 10/30/50/70/90/B0/D0/F0.

## Interface
- TIMEOUT, default 8: max FETCH cycles waiting for mem_ready before abort; must be 1..255.
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- opcode  in  8  instruction opcode, latched on start
- pc  in  16  address of the branch opcode, latched on start
- status_reg  in  8  P register (N=7, V=6, Z=1, C=0), latched on start
- busy  out  1  high in every state except IDLE
- mem_req  out  1  read request, high only in FETCH
- mem_addr  out  16  latched pc+1, mod 2^16
- mem_ready  in  1  read data valid this cycle
- mem_rdata  in  8  offset byte, captured when mem_req && mem_ready
- pc_out  out  16  resulting PC, held until next start
- pc_valid  out  1  one-cycle pulse in DONE
- taken  out  1  branch condition true, held with pc_out
- page_crossed  out  1  taken && (next_pc[15:8] != target[15:8]), held
- cycle_count  out  3  6502 cycles charged: 2, 3 or 4; 0 on illegal or timeout
- illegal  out  1  opcode not a branch, held
- timeout  out  1  fetch aborted, held

## Operation
- States: IDLE, FETCH, EVAL, TAKEN, FIXUP, DONE.
- IDLE, start=1, branch opcode: latch inputs, go to FETCH.
- IDLE, start=1, non-branch opcode: go to DONE with illegal=1, pc_out=pc, cycle_count=0, and no memory request.
- FETCH:
  - mem_req=1.
  - On mem_ready: capture offset, go to EVAL.
  - A wait counter increments each cycle without ready. At count TIMEOUT, go to DONE with timeout=1, pc_out=pc+2, taken=0, cycle_count=0.
- EVAL:
  - next_pc = pc+2 (16-bit wrap).
  - target = next_pc + sign-extended offset (16-bit wrap).
  - Evaluate the condition per opcode (BPL ~N, BMI N, BVC ~V, BVS V, BCC ~C, BCS C, BNE ~Z, BEQ Z) against the latched status.
  - Not taken: pc_out=next_pc, cycle_count=2, go to DONE.
  - Taken: go to TAKEN.
- TAKEN:
  - pc_out=target.
  - No page cross: cycle_count=3, go to DONE.
  - Page cross: go to FIXUP.
- FIXUP: cycle_count=4, go to DONE.
- DONE: pc_valid=1, go to IDLE.
- start outside IDLE is ignored; no queuing.
- Result outputs change only in EVAL/TAKEN/FIXUP/DONE of a new request, or on reset.
- Reset (asynchronous, any state, including mid-FETCH): state=IDLE, all outputs 0, pc_out=16'h0000. A pending memory read is dropped, and mem_req falls immediately.

## Timing
- start sampled at edge 0. FETCH occupies cycle 1 (plus W wait cycles), EVAL follows.
- pc_valid high in cycle 3+W (not taken), 4+W (taken), 5+W (taken, page cross).
- Illegal opcode: pc_valid in cycle 1.
- Timeout: pc_valid in cycle TIMEOUT+1.
- Back-to-back: start may be asserted in the DONE cycle but is not accepted until IDLE (the next cycle).
- mem_addr is stable for the whole FETCH residency. mem_rdata is sampled only on the ready cycle.

## Structure
- Shared package cpu6502_pkg holds:
  - state enum branch_seq_state_t
  - branch opcode localparams (OP_BPL..OP_BEQ)
  - status bit indices (P_N, P_V, P_Z, P_C)
- One sub-module, branch_offset_adder: purely combinational. Takes next_pc and offset; returns target and page-cross flag. Instantiated once, fed from latched registers.
- The FSM and counters live in branch_sequencer.

## Test plan
- BNE, Z=0, pc=16'h1000, offset 8'h10, mem_ready immediate -> mem_addr=16'h1001; pc_out=16'h1012, taken=1, page_crossed=0, cycle_count=3, pc_valid in cycle 4.
- BEQ, Z=0, pc=16'h2000, offset 8'h7F -> pc_out=16'h2002, taken=0, cycle_count=2, pc_valid in cycle 3.
- BMI, N=1, pc=16'h10FD, offset 8'h80 -> next_pc=16'h10FF, pc_out=16'h107F, no cross; then pc=16'h1100, offset 8'hF0 -> pc_out=16'h10F2, page_crossed=1, cycle_count=4, pc_valid in cycle 5.
- Wrap: pc=16'hFFFF -> mem_addr=16'h0000. BCS, C=1, offset 8'h02 -> pc_out=16'h0003, page_crossed=1.
- opcode 8'hEA with start -> no mem_req, illegal=1, pc_out=pc, cycle_count=0, pc_valid in cycle 1.
- mem_ready held low, TIMEOUT=8 -> timeout=1, pc_out=pc+2, pc_valid in cycle 9. Second run: rst_n low during FETCH -> busy=0, mem_req=0 and pc_out=0 asynchronously, no pc_valid.
